axis_inject_arb: RTL and testbench

AXIS_INJECT_ARB -- requirements
Module: axis_inject_arb

---
 rtl/axis_inject_arb_pkg.sv | 22 ++
 rtl/axis_skid2.sv | 62 ++++++
 rtl/axis_inject_arb.sv | 153 +++++++++++++++
 tb/tb_axis_inject_arb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_inject_arb_pkg.sv
// axis_inject_arb_pkg
//   Shared definitions for the AXI-Stream injection arbiter: default widths,
//   the arbiter FSM state type and a small index-width helper.
package axis_inject_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_TDATAW  = 32;
  localparam int DEF_TDESTW  = 4;
  localparam int DEF_CNTW    = 16;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never zero so a single-requester
  // build still has a legal pointer register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// axis_skid2
//   Two-entry FIFO used as the output skid buffer of the injection arbiter.
//   Full throughput (one beat per cycle) while out_ready stays high; the
//   second entry absorbs the beat already in flight when out_ready drops.
//   Ports:
//     clk, rst          clock and synchronous active-high reset
//     in_valid/in_ready upstream handshake, in_data payload
//     out_valid/out_ready downstream handshake, out_data payload
//   in_ready depends only on occupancy, so there is no combinational path
//   from out_ready to in_ready.
module axis_skid2 #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is cleared on reset as well so the payload outputs read zero
  // until the first beat arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_inject_arb.sv
// axis_inject_arb
//   Round-robin, packet-atomic arbiter that lets NUM_REQ AXI-Stream
//   requesters share one mesh input port, followed by a 2-entry skid buffer.
//   Ports:
//     CLK, RST                     clock, synchronous active-high reset
//     REQ_EN                       per-requester arbitration enable
//     S_TVALID/S_TREADY/S_TDATA/S_TLAST/S_TDEST  packed requester streams
//     M_TVALID/M_TREADY/M_TDATA/M_TLAST/M_TDEST  mesh-side stream
//     GRANT                        one-hot current owner, 0 while idle
//     PKT_CNT                      wrapping count of packets forwarded
module axis_inject_arb
  import axis_inject_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TDATAW  = DEF_TDATAW,
  parameter int TDESTW  = DEF_TDESTW,
  parameter int CNTW    = DEF_CNTW
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ_EN,
  input  logic [NUM_REQ-1:0]        S_TVALID,
  output logic [NUM_REQ-1:0]        S_TREADY,
  input  logic [NUM_REQ*TDATAW-1:0] S_TDATA,
  input  logic [NUM_REQ-1:0]        S_TLAST,
  input  logic [NUM_REQ*TDESTW-1:0] S_TDEST,
  output logic                      M_TVALID,
  input  logic                      M_TREADY,
  output logic [TDATAW-1:0]         M_TDATA,
  output logic                      M_TLAST,
  output logic [TDESTW-1:0]         M_TDEST,
  output logic [NUM_REQ-1:0]        GRANT,
  output logic [CNTW-1:0]           PKT_CNT
);

  localparam int IDXW = idx_width(NUM_REQ);
  localparam int PW   = TDATAW + TDESTW + 1;

  arb_state_e         state;
  logic [IDXW-1:0]    last_idx;
  logic [NUM_REQ-1:0] grant_q;
  logic [CNTW-1:0]    pkt_cnt_q;

  logic [NUM_REQ-1:0] req_vec;
  logic               pick_found;
  logic [IDXW-1:0]    pick_idx;
  int                 cand;
  logic [IDXW-1:0]    cand_idx;

  logic [TDATAW-1:0]  sel_data;
  logic [TDESTW-1:0]  sel_dest;
  logic               sel_last;
  logic               beat_fire;
  logic               beat_last;

  logic               buf_in_ready;
  logic [PW-1:0]      buf_out;

  // Round-robin search starting just after the last winner, so the most
  // recently served requester is considered last.
  always_comb begin
    req_vec    = S_TVALID & REQ_EN;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_idx) + k) % NUM_REQ;
      cand_idx = cand[IDXW-1:0];
      if (!pick_found && req_vec[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // The grant register is one-hot, so it directly selects the owner's beat.
  always_comb begin
    sel_data = '0;
    sel_dest = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data = S_TDATA[i*TDATAW +: TDATAW];
        sel_dest = S_TDEST[i*TDESTW +: TDESTW];
        sel_last = S_TLAST[i];
      end
    end
  end

  assign S_TREADY  = (state == ARB_BUSY && buf_in_ready) ? grant_q : '0;
  assign beat_fire = |(S_TVALID & S_TREADY);
  assign beat_last = |(S_TVALID & S_TREADY & S_TLAST);
  assign GRANT     = grant_q;
  assign PKT_CNT   = pkt_cnt_q;

  // REQ_EN only matters while choosing an owner; once BUSY the grant is held
  // until the owner's last beat is taken, which gives one idle cycle per packet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ARB_IDLE;
      last_idx <= IDXW'(NUM_REQ - 1);
      grant_q  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_q  <= NUM_REQ'(1) << pick_idx;
            last_idx <= pick_idx;
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (beat_last) begin
            grant_q <= '0;
            state   <= ARB_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

  // Counts packets as their last beat leaves on the mesh side.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pkt_cnt_q <= '0;
    end else if (M_TVALID && M_TREADY && M_TLAST) begin
      pkt_cnt_q <= pkt_cnt_q + CNTW'(1);
    end
  end

  axis_skid2 #(
    .W (PW)
  ) u_skid (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (beat_fire),
    .in_ready  (buf_in_ready),
    .in_data   ({sel_last, sel_dest, sel_data}),
    .out_valid (M_TVALID),
    .out_ready (M_TREADY),
    .out_data  (buf_out)
  );

  assign M_TDATA = buf_out[TDATAW-1:0];
  assign M_TDEST = buf_out[TDATAW +: TDESTW];
  assign M_TLAST = buf_out[PW-1];

endmodule

// File: tb/tb_axis_inject_arb.sv
// tb_axis_inject_arb
//   Directed bench for axis_inject_arb with NUM_REQ=2. A default-width
//   instance is the main DUT; a second instance with CNTW=4 shares every
//   input so the packet-counter wrap can be observed.
module tb_axis_inject_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  REQ_EN;
  logic [1:0]  S_TVALID;
  logic [1:0]  S_TREADY;
  logic [63:0] S_TDATA;
  logic [1:0]  S_TLAST;
  logic [7:0]  S_TDEST;
  logic        M_TVALID;
  logic        M_TREADY;
  logic [31:0] M_TDATA;
  logic        M_TLAST;
  logic [3:0]  M_TDEST;
  logic [1:0]  GRANT;
  logic [15:0] PKT_CNT;

  logic [1:0]  c4_s_tready;
  logic        c4_m_tvalid;
  logic [31:0] c4_m_tdata;
  logic        c4_m_tlast;
  logic [3:0]  c4_m_tdest;
  logic [1:0]  c4_grant;
  logic [3:0]  c4_pkt_cnt;

  always #5 CLK = ~CLK;

  axis_inject_arb #(
    .NUM_REQ (2), .TDATAW (32), .TDESTW (4), .CNTW (16)
  ) dut (
    .CLK (CLK), .RST (RST), .REQ_EN (REQ_EN),
    .S_TVALID (S_TVALID), .S_TREADY (S_TREADY), .S_TDATA (S_TDATA),
    .S_TLAST (S_TLAST), .S_TDEST (S_TDEST),
    .M_TVALID (M_TVALID), .M_TREADY (M_TREADY), .M_TDATA (M_TDATA),
    .M_TLAST (M_TLAST), .M_TDEST (M_TDEST),
    .GRANT (GRANT), .PKT_CNT (PKT_CNT)
  );

  axis_inject_arb #(
    .NUM_REQ (2), .TDATAW (32), .TDESTW (4), .CNTW (4)
  ) dut_c4 (
    .CLK (CLK), .RST (RST), .REQ_EN (REQ_EN),
    .S_TVALID (S_TVALID), .S_TREADY (c4_s_tready), .S_TDATA (S_TDATA),
    .S_TLAST (S_TLAST), .S_TDEST (S_TDEST),
    .M_TVALID (c4_m_tvalid), .M_TREADY (M_TREADY), .M_TDATA (c4_m_tdata),
    .M_TLAST (c4_m_tlast), .M_TDEST (c4_m_tdest),
    .GRANT (c4_grant), .PKT_CNT (c4_pkt_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
  } beat_t;

  typedef struct {
    logic        valid0;
    logic        last0;
    logic [31:0] data0;
    logic        mready;
    logic        exp_mvalid;
    logic [31:0] exp_mdata;
    logic        exp_mlast;
    logic [1:0]  exp_grant;
    logic [1:0]  exp_sready;
    logic [15:0] exp_cnt;
  } vec_t;

  int    vec_cnt = 0;
  int    miscompares = 0;

  beat_t src_q0[$];
  beat_t src_q1[$];
  beat_t got_q[$];
  beat_t exp_q[$];
  logic [1:0] grant_log[$];

  int          occ;
  int          pkt_model;
  logic [1:0]  req_en_drv;
  logic        mready_drv;
  logic        rst_drv;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [3:0]  prev_dest;
  logic        prev_last;
  int          saw_full;
  int          saw_wrap;
  logic [3:0]  last_c4;

  vec_t vecs[7];

  logic [1:0] run_val[$];
  int         run_len[$];
  int         gap_len[$];
  int         zeros;
  int         cnt01;
  int         cnt10;
  logic [1:0] first_grant;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushPkt(input int req, input logic [31:0] base, input int n, input logic [3:0] dest);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + 32'(i);
      b.dest = dest;
      b.last = (i == n - 1);
      if (req == 0) src_q0.push_back(b);
      else          src_q1.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic resetDut();
    @(negedge CLK);
    RST = 1'b1; S_TVALID = '0; S_TLAST = '0; S_TDATA = '0; S_TDEST = '0;
    REQ_EN = 2'b11; M_TREADY = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    req_en_drv = 2'b11; mready_drv = 1'b1; rst_drv = 1'b0;
    occ = 0; pkt_model = 0; prev_stall = 1'b0; saw_full = 0;
    src_q0.delete(); src_q1.delete(); got_q.delete(); exp_q.delete(); grant_log.delete();
  endtask

  // One cycle of queue-driven stimulus plus the per-cycle protocol checks.
  task automatic stepCycle();
    logic [1:0] fire_in;
    logic       fire_out;
    logic       fire_last;
    beat_t      b;
    @(negedge CLK);
    RST = rst_drv; REQ_EN = req_en_drv; M_TREADY = mready_drv;
    S_TVALID = '0; S_TLAST = '0; S_TDATA = '0; S_TDEST = '0;
    if (src_q0.size() > 0) begin
      S_TVALID[0] = 1'b1; S_TDATA[31:0] = src_q0[0].data;
      S_TDEST[3:0] = src_q0[0].dest; S_TLAST[0] = src_q0[0].last;
    end
    if (src_q1.size() > 0) begin
      S_TVALID[1] = 1'b1; S_TDATA[63:32] = src_q1[0].data;
      S_TDEST[7:4] = src_q1[0].dest; S_TLAST[1] = src_q1[0].last;
    end
    #1;
    checkOutput("m_tvalid_vs_occupancy", M_TVALID, occ != 0);
    if (occ == 2) begin
      saw_full = 1;
      checkOutput("s_tready_when_full", S_TREADY, 2'b00);
    end
    if (prev_stall) begin
      checkOutput("stall_hold_tdata", M_TDATA, prev_data);
      checkOutput("stall_hold_tdest", M_TDEST, prev_dest);
      checkOutput("stall_hold_tlast", M_TLAST, prev_last);
    end
    checkOutput("pkt_cnt", PKT_CNT, pkt_model % 65536);
    checkOutput("pkt_cnt_c4", c4_pkt_cnt, pkt_model % 16);
    if (last_c4 == 4'd15 && c4_pkt_cnt == 4'd0) saw_wrap = 1;
    last_c4 = c4_pkt_cnt;
    grant_log.push_back(GRANT);
    fire_in   = S_TVALID & S_TREADY;
    fire_out  = M_TVALID & M_TREADY;
    fire_last = fire_out & M_TLAST;
    if (fire_out) begin
      b.data = M_TDATA; b.dest = M_TDEST; b.last = M_TLAST;
      got_q.push_back(b);
    end
    prev_stall = M_TVALID & ~M_TREADY;
    prev_data = M_TDATA; prev_dest = M_TDEST; prev_last = M_TLAST;
    @(posedge CLK);
    if (fire_in[0]) void'(src_q0.pop_front());
    if (fire_in[1]) void'(src_q1.pop_front());
    if (rst_drv) begin
      occ = 0; pkt_model = 0; prev_stall = 1'b0;
    end else begin
      occ = occ + (fire_in != 2'b00 ? 1 : 0) - (fire_out ? 1 : 0);
      if (fire_last) pkt_model++;
    end
  endtask

  task automatic compareStream(input string name);
    int n;
    checkOutput({name, "_beat_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_data%0d", name, i), got_q[i].data, exp_q[i].data);
      checkOutput($sformatf("%s_dest%0d", name, i), got_q[i].dest, exp_q[i].dest);
      checkOutput($sformatf("%s_last%0d", name, i), got_q[i].last, exp_q[i].last);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    S_TVALID = {1'b0, v.valid0};
    S_TLAST  = {1'b0, v.last0};
    S_TDATA  = {32'h0, v.data0};
    S_TDEST  = 8'h01;
    M_TREADY = v.mready;
    #1;
  endtask

  task automatic checkRow(input int i, input vec_t v);
    checkOutput($sformatf("row%0d_m_tvalid", i), M_TVALID, v.exp_mvalid);
    checkOutput($sformatf("row%0d_grant", i), GRANT, v.exp_grant);
    checkOutput($sformatf("row%0d_s_tready", i), S_TREADY, v.exp_sready);
    checkOutput($sformatf("row%0d_pkt_cnt", i), PKT_CNT, v.exp_cnt);
    if (v.exp_mvalid) begin
      checkOutput($sformatf("row%0d_m_tdata", i), M_TDATA, v.exp_mdata);
      checkOutput($sformatf("row%0d_m_tlast", i), M_TLAST, v.exp_mlast);
      checkOutput($sformatf("row%0d_m_tdest", i), M_TDEST, 4'h1);
    end
  endtask

  initial begin
    last_c4 = 4'd0; saw_wrap = 0;

    // Single 4-beat packet on req0: valid,last,data,mready | mvalid,mdata,mlast,grant,sready,cnt
    vecs[0] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h00, 1'b0, 2'b00, 2'b00, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h00, 1'b0, 2'b01, 2'b01, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 32'h10, 1'b0, 2'b01, 2'b01, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 32'h12, 1'b1, 1'b1, 32'h11, 1'b0, 2'b01, 2'b01, 16'd0};
    vecs[4] = '{1'b1, 1'b1, 32'h13, 1'b1, 1'b1, 32'h12, 1'b0, 2'b01, 2'b01, 16'd0};
    vecs[5] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h13, 1'b1, 2'b00, 2'b00, 16'd0};
    vecs[6] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 2'b00, 2'b00, 16'd1};

    $display("[TB] reset state");
    resetDut();
    #1;
    checkOutput("reset_m_tvalid", M_TVALID, 1'b0);
    checkOutput("reset_m_tdata", M_TDATA, 32'h0);
    checkOutput("reset_m_tlast", M_TLAST, 1'b0);
    checkOutput("reset_m_tdest", M_TDEST, 4'h0);
    checkOutput("reset_grant", GRANT, 2'b00);
    checkOutput("reset_s_tready", S_TREADY, 2'b00);
    checkOutput("reset_pkt_cnt", PKT_CNT, 16'd0);

    $display("[TB] single packet table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkRow(i, vecs[i]);
    end

    $display("[TB] alternating requesters");
    resetDut();
    pushPkt(0, 32'hA0, 2, 4'h2);
    pushPkt(1, 32'hB0, 2, 4'h3);
    pushPkt(0, 32'hA2, 2, 4'h2);
    pushPkt(1, 32'hB2, 2, 4'h3);
    for (int c = 0; c < 60; c++) begin
      stepCycle();
      if (src_q0.size() == 0 && src_q1.size() == 0 && occ == 0) break;
    end
    checkOutput("alt_drained", (src_q0.size() == 0 && src_q1.size() == 0 && occ == 0), 1'b1);
    compareStream("alt");
    run_val.delete(); run_len.delete(); gap_len.delete(); zeros = 0;
    for (int i = 0; i < grant_log.size(); i++) begin
      if (grant_log[i] == 2'b00) begin
        zeros++;
      end else if (i > 0 && grant_log[i-1] == grant_log[i]) begin
        run_len[run_len.size()-1]++;
      end else begin
        if (run_val.size() > 0) gap_len.push_back(zeros);
        run_val.push_back(grant_log[i]);
        run_len.push_back(1);
        zeros = 0;
      end
    end
    checkOutput("alt_grant_runs", run_val.size(), 4);
    for (int i = 0; i < run_val.size() && i < 4; i++) begin
      checkOutput($sformatf("alt_grant%0d", i), run_val[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("alt_busy_len%0d", i), run_len[i], 2);
    end
    for (int i = 0; i < gap_len.size(); i++)
      checkOutput($sformatf("alt_idle_gap%0d", i), gap_len[i], 1);
    @(negedge CLK); #1;
    checkOutput("alt_pkt_cnt", PKT_CNT, 16'd4);

    $display("[TB] output stall");
    resetDut();
    pushPkt(0, 32'h20, 4, 4'h5);
    for (int c = 0; c < 3; c++) stepCycle();
    mready_drv = 1'b0;
    for (int c = 0; c < 5; c++) stepCycle();
    mready_drv = 1'b1;
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      if (src_q0.size() == 0 && occ == 0) break;
    end
    checkOutput("stall_drained", (src_q0.size() == 0 && occ == 0), 1'b1);
    checkOutput("stall_buffer_filled", saw_full, 1);
    compareStream("stall");
    @(negedge CLK); #1;
    checkOutput("stall_pkt_cnt", PKT_CNT, 16'd1);

    $display("[TB] request enable masking");
    resetDut();
    req_en_drv = 2'b10;
    pushPkt(0, 32'h30, 2, 4'h6);
    exp_q.delete();
    pushPkt(1, 32'h40, 3, 4'h7);
    for (int c = 0; c < 2; c++) stepCycle();
    req_en_drv = 2'b00;
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      if (src_q1.size() == 0 && occ == 0) break;
    end
    checkOutput("en_drained", (src_q1.size() == 0 && occ == 0), 1'b1);
    cnt01 = 0; cnt10 = 0;
    foreach (grant_log[i]) begin
      if (grant_log[i] == 2'b01) cnt01++;
      if (grant_log[i] == 2'b10) cnt10++;
    end
    checkOutput("en_req0_never_granted", cnt01, 0);
    checkOutput("en_req1_busy_cycles", cnt10, 3);
    checkOutput("en_req0_untouched", src_q0.size(), 2);
    compareStream("en");
    @(negedge CLK); #1;
    checkOutput("en_pkt_cnt", PKT_CNT, 16'd1);

    $display("[TB] reset mid-packet");
    resetDut();
    pushPkt(0, 32'h50, 4, 4'h8);
    for (int c = 0; c < 3; c++) stepCycle();
    rst_drv = 1'b1;
    stepCycle();
    rst_drv = 1'b0;
    src_q0.delete(); got_q.delete(); exp_q.delete(); grant_log.delete();
    @(negedge CLK);
    RST = 1'b0; S_TVALID = '0; S_TLAST = '0;
    #1;
    checkOutput("rst_mid_m_tvalid", M_TVALID, 1'b0);
    checkOutput("rst_mid_m_tdata", M_TDATA, 32'h0);
    checkOutput("rst_mid_m_tlast", M_TLAST, 1'b0);
    checkOutput("rst_mid_m_tdest", M_TDEST, 4'h0);
    checkOutput("rst_mid_grant", GRANT, 2'b00);
    checkOutput("rst_mid_s_tready", S_TREADY, 2'b00);
    checkOutput("rst_mid_pkt_cnt", PKT_CNT, 16'd0);
    pushPkt(0, 32'h70, 1, 4'hA);
    pushPkt(1, 32'h60, 2, 4'h9);
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      if (src_q0.size() == 0 && src_q1.size() == 0 && occ == 0) break;
    end
    checkOutput("rst_mid_drained", (src_q0.size() == 0 && src_q1.size() == 0 && occ == 0), 1'b1);
    first_grant = 2'b00;
    foreach (grant_log[i]) begin
      if (first_grant == 2'b00 && grant_log[i] != 2'b00) first_grant = grant_log[i];
    end
    checkOutput("rst_mid_first_grant", first_grant, 2'b01);
    compareStream("rst_mid");

    $display("[TB] packet counter wrap");
    resetDut();
    saw_wrap = 0; last_c4 = 4'd0;
    for (int i = 0; i < 17; i++) pushPkt(0, 32'h80 + 32'(i), 1, 4'hB);
    for (int c = 0; c < 120; c++) begin
      stepCycle();
      if (src_q0.size() == 0 && occ == 0) break;
    end
    checkOutput("wrap_drained", (src_q0.size() == 0 && occ == 0), 1'b1);
    compareStream("wrap");
    @(negedge CLK); #1;
    checkOutput("wrap_seen_15_to_0", saw_wrap, 1);
    checkOutput("wrap_c4_pkt_cnt", c4_pkt_cnt, 4'd1);
    checkOutput("wrap_wide_pkt_cnt", PKT_CNT, 16'd17);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
